ofdm_rx_byte_packer: RTL and testbench
======================================

// Module: ofdm_rx_byte_packer
// PURPOSE
// Downstream consumer of the OFDM RX path. Takes demapped carrier bits
// (rx_rcv_data/_valid/_start) and packs them MSB-first into bytes. Bytes are
// buffered in a small FIFO and presented on a valid/ready byte stream, with a
// start-of-symbol tag. Also provides symbol count, symbol-error and overflow
// status for the RX bench and MAC.
// PARAMETERS
// bits_per_carrier_c  2   width of rx_rcv_data; must divide 8 (1,2,4,8)
// data_carriers_c     64  carriers per OFDM symbol; data_carriers_c*bits_per_carrier_c % 8 == 0
// fifo_depth_c        16  byte FIFO entries, power of 2, >= 2
// sym_cnt_width_c     16  width of symbol counter
// PORTS
// sys_clk             in   1                  system clock, rising edge
// sys_rst             in   1                  async reset, active-high
// sys_init            in   1                  sync clear of FSM, FIFO, counters, flags
// rx_rcv_data         in   bits_per_carrier_c demapped bits of one carrier
// rx_rcv_data_valid   in   1                  rx_rcv_data valid this cycle
// rx_rcv_data_start   in   1                  first carrier of a symbol (qualified by valid)
// byte_data           out  8                  FIFO head byte
// byte_sof            out  1                  head byte is first byte of its symbol
// byte_valid          out  1                  FIFO not empty
// byte_ready          in   1                  consumer accepts head when byte_valid
// sym_count           out  sym_cnt_width_c    completed symbols, wraps to 0
// sym_err             out  1                  1-cycle pulse: symbol aborted by early start
// overflow            out  1                  sticky: byte dropped on full FIFO
// BEHAVIOUR
// - Reset (sys_rst=1, async) and sys_init=1 (sync): FSM=WAIT_START, carrier/bit
//   counters=0, FIFO empty; byte_data=0, byte_sof=0, byte_valid=0, sym_count=0,
//   sym_err=0, overflow=0. sys_init has priority over all other inputs.
// - Beat = cycle with rx_rcv_data_valid=1. Non-beat cycles change nothing.
// - FSM WAIT_START: beats without start ignored. Beat with start -> shift
//   carrier in, carrier_cnt=1, mark next byte SOF, -> PACKING.
// - FSM PACKING: beat without start -> shift in, carrier_cnt++. On beat that
//   makes carrier_cnt==data_carriers_c: sym_count++ (next cycle), -> WAIT_START.
// - Beat with start in PACKING (carrier_cnt!=0): sym_err pulse, partial byte
//   discarded, bytes already pushed stay; beat treated as new symbol start.
// - Packing: sr <= {sr[7-W:0], rx_rcv_data}, W=bits_per_carrier_c; first
//   carrier lands in MSBs. After 8/W beats the byte is pushed to FIFO.
// - Latency: byte_valid (empty FIFO) rises the cycle after the completing beat.
// - FIFO: pop when byte_valid&&byte_ready. Push when full and no pop -> byte
//   dropped, overflow set (sticky). Push and pop same cycle while full -> both
//   done, no overflow. Pop when empty is ignored. byte_sof stored per entry.
// - byte_data/byte_sof hold stable while byte_valid=1 and byte_ready=0.
// - sym_count wraps from 2^sym_cnt_width_c-1 to 0.
// TESTING
// 1 W=2, 64 carriers, ready=1, carriers 0..63 = 2'b11,2'b00 repeating ->
//   16 bytes 8'hCC, first with byte_sof=1; sym_count=1; sym_err never 1.
// 2 Beats before any start (10 x 2'b01) then normal symbol -> pre-start data
//   absent; exactly 16 bytes out.
// 3 Start at carrier 10 of a symbol -> sym_err 1-cycle pulse, 2 bytes from
//   aborted symbol kept, new symbol yields 16 bytes, sym_count=1.
// 4 byte_ready=0 for a full symbol (16 bytes, depth 16) then 1 more symbol ->
//   FIFO holds first 16, overflow=1, first new byte dropped; sys_init clears all.
// 5 Random valid gaps and byte_ready toggling over 100 symbols -> byte stream
//   equals model, sym_count=100, overflow=0 with ready duty >= 50%.
// 6 Assert sys_rst mid-symbol (carrier 30) -> all outputs 0 at once; next
//   start produces a clean symbol.

Source files
------------

// File: rtl/ofdm_rx_byte_packer.sv
// Packs demapped OFDM carrier bits MSB-first into bytes and queues them in a
// small FIFO behind a valid/ready byte stream, with symbol/error/overflow status.
module ofdm_rx_byte_packer #(
  parameter int bits_per_carrier_c = 2,
  parameter int data_carriers_c    = 64,
  parameter int fifo_depth_c       = 16,
  parameter int sym_cnt_width_c    = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          sys_init,
  input  logic [bits_per_carrier_c-1:0] rx_rcv_data,
  input  logic                          rx_rcv_data_valid,
  input  logic                          rx_rcv_data_start,
  output logic [7:0]                    byte_data,
  output logic                          byte_sof,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic [sym_cnt_width_c-1:0]    sym_count,
  output logic                          sym_err,
  output logic                          overflow
);

  localparam int W    = bits_per_carrier_c;
  localparam int BPB  = 8 / W;
  localparam int CC_W = $clog2(data_carriers_c + 1);
  localparam int BC_W = $clog2(BPB + 1);
  localparam int AW   = (fifo_depth_c > 1) ? $clog2(fifo_depth_c) : 1;

  typedef enum logic {WAIT_START, PACKING} state_t;

  typedef struct packed {
    logic       sof;
    logic [7:0] data;
  } ent_t;

  state_t                     state_q, state_d;
  logic [CC_W-1:0]            car_cnt_q, car_cnt_d;
  logic [BC_W-1:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]                 sr_q, sr_d;
  logic                       sof_pend_q, sof_pend_d;
  logic [sym_cnt_width_c-1:0] sym_cnt_q, sym_cnt_d;
  logic                       sym_err_q, sym_err_d;
  logic                       ovf_q;

  logic                       take, first, sof_cur, push;
  logic [7:0]                 sr_base;
  logic [7+W:0]               sr_wide;
  logic [BC_W-1:0]            bcnt_nxt;
  logic [CC_W-1:0]            ccnt_nxt;
  ent_t                       push_ent;

  // A start beat always opens a fresh symbol; in PACKING it also aborts the old one.
  always_comb begin
    state_d    = state_q;
    car_cnt_d  = car_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    sof_pend_d = sof_pend_q;
    sym_cnt_d  = sym_cnt_q;
    sym_err_d  = 1'b0;
    take       = 1'b0;
    first      = 1'b0;
    sof_cur    = 1'b0;
    push       = 1'b0;
    push_ent   = '0;
    sr_base    = sr_q;
    sr_wide    = '0;
    bcnt_nxt   = '0;
    ccnt_nxt   = '0;
    if (rx_rcv_data_valid) begin
      if (rx_rcv_data_start) begin
        take      = 1'b1;
        first     = 1'b1;
        sym_err_d = (state_q == PACKING);
      end else if (state_q == PACKING) begin
        take = 1'b1;
      end
    end
    if (take) begin
      // Discarded partial bits are cleared so they can never leak into a byte.
      sr_base  = first ? 8'h00 : sr_q;
      sr_wide  = {sr_base, rx_rcv_data};
      sr_d     = sr_wide[7:0];
      bcnt_nxt = first ? BC_W'(1) : bit_cnt_q + BC_W'(1);
      ccnt_nxt = first ? CC_W'(1) : car_cnt_q + CC_W'(1);
      sof_cur  = first | sof_pend_q;
      if (bcnt_nxt == BC_W'(BPB)) begin
        push       = 1'b1;
        push_ent   = '{sof: sof_cur, data: sr_wide[7:0]};
        bit_cnt_d  = '0;
        sof_pend_d = 1'b0;
      end else begin
        bit_cnt_d  = bcnt_nxt;
        sof_pend_d = sof_cur;
      end
      if (ccnt_nxt == CC_W'(data_carriers_c)) begin
        car_cnt_d = '0;
        state_d   = WAIT_START;
        sym_cnt_d = sym_cnt_q + 1'b1;
      end else begin
        car_cnt_d = ccnt_nxt;
        state_d   = PACKING;
      end
    end
  end

  // Byte FIFO: pointers carry one extra wrap bit to tell full from empty.
  ent_t        mem [fifo_depth_c];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, pop, wr_en, ovf_set;
  ent_t        head;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = !empty && byte_ready;
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign head    = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge sys_clk) begin
    if (wr_en && !sys_init) mem[wr_ptr_q[AW-1:0]] <= push_ent;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= WAIT_START;
      car_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      sof_pend_q <= 1'b0;
      sym_cnt_q  <= '0;
      sym_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else if (sys_init) begin
      state_q    <= WAIT_START;
      car_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      sof_pend_q <= 1'b0;
      sym_cnt_q  <= '0;
      sym_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      car_cnt_q  <= car_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      sof_pend_q <= sof_pend_d;
      sym_cnt_q  <= sym_cnt_d;
      sym_err_q  <= sym_err_d;
      ovf_q      <= ovf_q | ovf_set;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign byte_valid = !empty;
  assign byte_data  = empty ? 8'h00 : head.data;
  assign byte_sof   = !empty && head.sof;
  assign sym_count  = sym_cnt_q;
  assign sym_err    = sym_err_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ofdm_rx_byte_packer.sv
// Randomised bench for ofdm_rx_byte_packer: a carrier-list/queue model is compared
// every cycle, plus literal expectations for the directed scenarios.
module tb_ofdm_rx_byte_packer;
  localparam int W = 2, N = 64, DEPTH = 16, BPB = 8 / W;

  logic       sys_clk = 0, sys_rst = 1, sys_init = 0;
  logic [1:0] rx_rcv_data = 0;
  logic       rx_rcv_data_valid = 0, rx_rcv_data_start = 0;
  logic [7:0] byte_data;
  logic       byte_sof, byte_valid, byte_ready = 0;
  logic [15:0] sym_count;
  logic       sym_err, overflow;

  ofdm_rx_byte_packer #(.bits_per_carrier_c(W), .data_carriers_c(N),
                        .fifo_depth_c(DEPTH), .sym_cnt_width_c(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sys_init(sys_init),
    .rx_rcv_data(rx_rcv_data), .rx_rcv_data_valid(rx_rcv_data_valid),
    .rx_rcv_data_start(rx_rcv_data_start), .byte_data(byte_data),
    .byte_sof(byte_sof), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .sym_count(sym_count), .sym_err(sym_err), .overflow(overflow));

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0, n_fail = 0, n_errp = 0;
  bit rnd_ready = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: carriers of the open symbol as a list, FIFO as a queue.
  int          cur[$];
  bit          in_sym = 0;
  bit [8:0]    mq[$];
  logic [15:0] m_cnt = 0;
  bit          m_err = 0, m_ovf = 0;
  bit [8:0]    got[$];

  always @(posedge sys_clk) begin
    if (sys_rst || sys_init) begin
      cur.delete(); mq.delete(); in_sym = 0; m_cnt = 0; m_err = 0; m_ovf = 0;
    end else begin
      m_err = 0;
      if (mq.size() != 0 && byte_ready) void'(mq.pop_front());
      if (rx_rcv_data_valid && (rx_rcv_data_start || in_sym)) begin
        if (rx_rcv_data_start) begin
          if (in_sym) m_err = 1;
          cur.delete();
          in_sym = 1;
        end
        cur.push_back(int'(rx_rcv_data));
        if (cur.size() % BPB == 0) begin
          int b = 0;
          for (int k = cur.size() - BPB; k < cur.size(); k++) b = (b << W) | cur[k];
          if (mq.size() < DEPTH) mq.push_back({cur.size() == BPB, b[7:0]});
          else m_ovf = 1;
        end
        if (cur.size() == N) begin
          m_cnt++;
          in_sym = 0;
          cur.delete();
        end
      end
    end
  end

  always @(posedge sys_clk)
    if (!sys_rst && !sys_init && byte_valid && byte_ready) got.push_back({byte_sof, byte_data});

  always @(posedge sys_clk) begin
    #1;
    check("byte_valid", byte_valid, mq.size() != 0);
    check("byte_data", byte_data, mq.size() != 0 ? int'(mq[0][7:0]) : 0);
    check("byte_sof", byte_sof, mq.size() != 0 ? int'(mq[0][8]) : 0);
    check("sym_count", sym_count, m_cnt);
    check("sym_err", sym_err, m_err);
    check("overflow", overflow, m_ovf);
    if (sym_err) n_errp++;
  end

  always @(negedge sys_clk) if (rnd_ready) byte_ready = ($urandom_range(0, 3) != 0);

  // mode 0: 11,00 repeating; 1: random; 2: constant 01
  task automatic send_sym(input int mode, input int ncar, input bit gaps);
    for (int c = 0; c < ncar; c++) begin
      if (gaps && $urandom_range(0, 9) < 3) begin
        rx_rcv_data_valid = 0;
        rx_rcv_data_start = $urandom_range(0, 1);
        repeat ($urandom_range(1, 3)) @(negedge sys_clk);
      end
      rx_rcv_data_valid = 1;
      rx_rcv_data_start = (c == 0);
      rx_rcv_data = (mode == 0) ? ((c % 2 == 0) ? 2'b11 : 2'b00) :
                    (mode == 1) ? 2'($urandom_range(0, 3)) : 2'b01;
      @(negedge sys_clk);
    end
    rx_rcv_data_valid = 0;
    rx_rcv_data_start = 0;
  endtask

  task automatic drain();
    byte_ready = 1;
    for (int i = 0; i < 300 && byte_valid; i++) @(negedge sys_clk);
    check("drain_done", byte_valid, 0);
  endtask

  task automatic init_pulse();
    sys_init = 1;
    @(negedge sys_clk);
    sys_init = 0;
    got.delete();
    n_errp = 0;
  endtask

  function automatic int count_not(input bit [8:0] v, input int from);
    int n = 0;
    for (int i = from; i < got.size(); i++) if (got[i][7:0] != v[7:0]) n++;
    return n;
  endfunction

  initial begin
    repeat (3) @(negedge sys_clk);
    check("rst_valid", byte_valid, 0);
    check("rst_data", byte_data, 0);
    check("rst_count", sym_count, 0);
    check("rst_ovf", overflow, 0);
    sys_rst = 0;
    @(negedge sys_clk);

    // 1: one clean symbol
    byte_ready = 1; got.delete(); n_errp = 0;
    send_sym(0, N, 0);
    drain();
    check("t1_nbytes", got.size(), 16);
    check("t1_notCC", count_not(9'h0CC, 0), 0);
    check("t1_sof0", got.size() > 0 ? int'(got[0][8]) : -1, 1);
    check("t1_sof1", got.size() > 1 ? int'(got[1][8]) : -1, 0);
    check("t1_symcnt", sym_count, 1);
    check("t1_errp", n_errp, 0);

    // 2: beats before any start are ignored
    init_pulse();
    rx_rcv_data_valid = 1; rx_rcv_data = 2'b01;
    repeat (10) @(negedge sys_clk);
    rx_rcv_data_valid = 0;
    send_sym(0, N, 0);
    drain();
    check("t2_nbytes", got.size(), 16);
    check("t2_notCC", count_not(9'h0CC, 0), 0);
    check("t2_symcnt", sym_count, 1);

    // 3: early start at carrier 10 aborts the symbol
    init_pulse();
    send_sym(0, 10, 0);
    send_sym(0, N, 0);
    drain();
    check("t3_nbytes", got.size(), 18);
    check("t3_errp", n_errp, 1);
    check("t3_symcnt", sym_count, 1);
    check("t3_sof_new", got.size() > 2 ? int'(got[2][8]) : -1, 1);
    check("t3_notCC", count_not(9'h0CC, 0), 0);

    // 4: stalled consumer fills FIFO then overflows
    init_pulse();
    byte_ready = 0;
    send_sym(0, N, 0);
    repeat (2) @(negedge sys_clk);
    check("t4_ovf_pre", overflow, 0);
    send_sym(2, N, 0);
    @(negedge sys_clk);
    check("t4_ovf", overflow, 1);
    drain();
    check("t4_nbytes", got.size(), 16);
    check("t4_notCC", count_not(9'h0CC, 0), 0);
    check("t4_ovf_sticky", overflow, 1);
    check("t4_symcnt", sym_count, 2);
    init_pulse();
    check("t4_init_ovf", overflow, 0);
    check("t4_init_cnt", sym_count, 0);
    check("t4_init_valid", byte_valid, 0);

    // 5: random data, valid gaps, ready toggling
    init_pulse();
    rnd_ready = 1;
    for (int s = 0; s < 100; s++) send_sym(1, N, 1);
    rnd_ready = 0;
    drain();
    check("t5_symcnt", sym_count, 100);
    check("t5_ovf", overflow, 0);
    check("t5_nbytes", got.size(), 1600);

    // 6: async reset mid-symbol
    init_pulse();
    byte_ready = 0;
    send_sym(0, 30, 0);
    sys_rst = 1;
    #1;
    check("t6_valid", byte_valid, 0);
    check("t6_data", byte_data, 0);
    check("t6_sof", byte_sof, 0);
    check("t6_cnt", sym_count, 0);
    check("t6_err", sym_err, 0);
    check("t6_ovf", overflow, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 0;
    got.delete();
    byte_ready = 1;
    send_sym(0, N, 0);
    drain();
    check("t6_nbytes", got.size(), 16);
    check("t6_first", got.size() > 0 ? int'(got[0]) : -1, 9'h1CC);
    check("t6_symcnt", sym_count, 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
